// File: rtl/mem_dump_master_pkg.sv
// mem_dump_master_pkg: shared constants, FSM state type and count clamp helper
package mem_dump_master_pkg;
   localparam int ADDR_W    = 7;
   localparam int DATA_W    = 32;
   localparam int MEM_WORDS = 128;
   localparam logic MODE_DUMP = 1'b0;
   localparam logic MODE_FILL = 1'b1;
   typedef enum logic [2:0] {IDLE, REQ, RD, HOLD, WR, DONE} state_t;
   // counts beyond the memory depth clamp to one full pass
   function automatic logic [7:0] eff_count(input logic [7:0] c);
      return (c > 8'(MEM_WORDS)) ? 8'(MEM_WORDS) : c;
   endfunction
endpackage

// File: rtl/mem_dump_master.sv
// mem_dump_master: bus initiator that dumps a memory block to a valid/ready port or fills it with a pattern
//   CLK/RST_N            clock, async active-low reset
//   start/mode/inc       command strobe, 0=dump 1=fill, incrementing fill
//   base_addr/count      block start address and length (0 = no-op, >128 clamps)
//   fill_data            fill seed
//   bus_req/bus_gnt      arbiter handshake
//   CS/WE/ADDR/Mem_Bus   memory interface, Mem_Bus driven only while writing
//   out_valid/out_data/out_addr/out_ready  dump stream
//   busy/done            command in flight, one-cycle completion pulse
module mem_dump_master
   import mem_dump_master_pkg::*;
(
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              start,
   input  logic              mode,
   input  logic              inc,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [7:0]        count,
   input  logic [DATA_W-1:0] fill_data,
   output logic              bus_req,
   input  logic              bus_gnt,
   output logic              CS,
   output logic              WE,
   output logic [ADDR_W-1:0] ADDR,
   inout  wire  [DATA_W-1:0] Mem_Bus,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic [ADDR_W-1:0] out_addr,
   input  logic              out_ready,
   output logic              busy,
   output logic              done
);
   state_t            state;
   logic              mode_q, inc_q, drive;
   logic [ADDR_W-1:0] base_q, nxt_addr;
   logic [DATA_W-1:0] fill_q, wdata, nxt_data;
   logic [7:0]        idx, eff, nxt;
   logic              last;
   assign nxt      = idx + 8'd1;
   assign last     = nxt == eff;
   assign nxt_addr = base_q + nxt[ADDR_W-1:0];
   assign nxt_data = inc_q ? fill_q + DATA_W'(nxt) : fill_q;
   // the drive enable is a flop cleared by the async reset, so the bus floats the moment RST_N falls
   assign Mem_Bus  = drive ? wdata : 'z;
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state     <= IDLE;
         bus_req   <= 1'b0;
         CS        <= 1'b0;
         WE        <= 1'b0;
         ADDR      <= '0;
         drive     <= 1'b0;
         wdata     <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_addr  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         mode_q    <= 1'b0;
         inc_q     <= 1'b0;
         base_q    <= '0;
         fill_q    <= '0;
         idx       <= '0;
         eff       <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (start) begin
               mode_q  <= mode;
               inc_q   <= inc;
               base_q  <= base_addr;
               fill_q  <= fill_data;
               eff     <= eff_count(count);
               idx     <= '0;
               busy    <= 1'b1;
               state   <= (count == 8'd0) ? DONE : REQ;
               done    <= count == 8'd0;
               bus_req <= count != 8'd0;
            end
            REQ: if (bus_gnt) begin
               state <= (mode_q == MODE_FILL) ? WR : RD;
               CS    <= 1'b1;
               WE    <= mode_q;
               drive <= mode_q;
               ADDR  <= base_q + idx[ADDR_W-1:0];
               wdata <= inc_q ? fill_q + DATA_W'(idx) : fill_q;
            end
            RD: begin
               out_data  <= Mem_Bus;
               out_addr  <= ADDR;
               out_valid <= 1'b1;
               CS        <= 1'b0;
               ADDR      <= '0;
               state     <= HOLD;
            end
            HOLD: if (out_ready) begin
               out_valid <= 1'b0;
               idx       <= nxt;
               state     <= last ? DONE : (bus_gnt ? RD : REQ);
               done      <= last;
               bus_req   <= !last;
               CS        <= !last && bus_gnt;
               ADDR      <= (!last && bus_gnt) ? nxt_addr : '0;
            end
            // the word in flight always completes; a lost grant only defers the next index
            WR: begin
               idx   <= nxt;
               wdata <= nxt_data;
               if (last || !bus_gnt) begin
                  CS      <= 1'b0;
                  WE      <= 1'b0;
                  drive   <= 1'b0;
                  ADDR    <= '0;
                  state   <= last ? DONE : REQ;
                  done    <= last;
                  bus_req <= !last;
               end else begin
                  ADDR <= nxt_addr;
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_dump_master.sv
// tb_mem_dump_master: directed self-checking bench with a negedge-acting memory model
module tb_mem_dump_master;
   logic        CLK = 1'b0, RST_N = 1'b0;
   logic        start = 1'b0, mode = 1'b0, inc = 1'b0, bus_gnt = 1'b1, out_ready = 1'b0;
   logic [6:0]  base_addr = '0;
   logic [7:0]  count = '0;
   logic [31:0] fill_data = '0;
   logic        bus_req, CS, WE, out_valid, busy, done;
   logic [6:0]  ADDR, out_addr;
   logic [31:0] out_data;
   wire  [31:0] mem_bus;
   int tests = 0, fails = 0;

   mem_dump_master dut (
      .CLK(CLK), .RST_N(RST_N), .start(start), .mode(mode), .inc(inc),
      .base_addr(base_addr), .count(count), .fill_data(fill_data),
      .bus_req(bus_req), .bus_gnt(bus_gnt), .CS(CS), .WE(WE), .ADDR(ADDR),
      .Mem_Bus(mem_bus), .out_valid(out_valid), .out_data(out_data),
      .out_addr(out_addr), .out_ready(out_ready), .busy(busy), .done(done)
   );

   always #5 CLK = ~CLK;

   logic [31:0] ram [128];
   logic        mem_oe = 1'b0;
   logic [31:0] mem_rd = '0;
   always @(negedge CLK) begin
      if (CS && WE) ram[ADDR] <= mem_bus;
      mem_oe <= CS && !WE;
      if (CS && !WE) mem_rd <= ram[ADDR];
   end
   assign mem_bus = (mem_oe && CS) ? mem_rd : 'z;

   int cyc = 0;
   int wr_addr[$], wr_cyc[$], cs_cyc[$], done_cyc[$], oa_q[$];
   logic [31:0] od_q[$];
   always @(negedge CLK) begin
      cyc++;
      if (CS) cs_cyc.push_back(cyc);
      if (CS && WE) begin
         wr_addr.push_back(int'(ADDR));
         wr_cyc.push_back(cyc);
      end
      if (out_valid) begin
         od_q.push_back(out_data);
         oa_q.push_back(int'(out_addr));
      end
      if (done) done_cyc.push_back(cyc);
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d fails=%0d", tests, fails);
      $fatal(1, "watchdog");
   end

   task automatic go(input logic m, input logic i_, input logic [6:0] b, input logic [7:0] c, input logic [31:0] f);
      @(negedge CLK);
      mode = m; inc = i_; base_addr = b; count = c; fill_data = f; start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
   endtask

   task automatic wait_done(input int lim, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < lim && !ok; k++) begin
         if (done) ok = 1'b1;
         else @(negedge CLK);
      end
   endtask

   task automatic test_reset;
      #12;
      tests++;
      if ({bus_req, CS, WE, ADDR, busy, done, out_valid, out_data, out_addr} !== '0) begin
         fails++;
         $display("FAIL reset_outputs: got req=%b cs=%b we=%b addr=%0d busy=%b done=%b vld=%b, want all 0", bus_req, CS, WE, ADDR, busy, done, out_valid);
      end
      tests++;
      if (mem_bus !== 32'bz && mem_bus !== 32'd0) begin
         fails++;
         $display("FAIL reset_bus: Mem_Bus=%h, want released", mem_bus);
      end
      @(negedge CLK);
      RST_N = 1'b1;
   endtask

   task automatic test_fill_inc;
      bit ok;
      int sw = wr_addr.size(), sd = done_cyc.size();
      go(1'b1, 1'b1, 7'h10, 8'd4, 32'hA0);
      wait_done(20, ok);
      repeat (3) @(negedge CLK);
      tests++;
      if (!ok) begin fails++; $display("FAIL fill_inc_done: no done within 20 cycles"); end
      tests++;
      if (wr_addr.size() - sw != 4) begin
         fails++;
         $display("FAIL fill_inc_writes: got %0d writes, want 4", wr_addr.size() - sw);
      end else begin
         tests++;
         if (wr_cyc[sw+3] - wr_cyc[sw] != 3) begin
            fails++;
            $display("FAIL fill_inc_consecutive: span %0d cycles, want 3", wr_cyc[sw+3] - wr_cyc[sw]);
         end
      end
      for (int k = 0; k < 4; k++) begin
         tests++;
         if (ram[16+k] !== 32'hA0 + k) begin
            fails++;
            $display("FAIL fill_inc_ram[%0d]: got %h, want %h", 16 + k, ram[16+k], 32'hA0 + k);
         end
      end
      tests++;
      if (done_cyc.size() - sd != 1) begin
         fails++;
         $display("FAIL fill_inc_done_pulses: got %0d, want 1", done_cyc.size() - sd);
      end
      tests++;
      if ((mem_bus !== 32'bz && mem_bus !== 32'd0) || busy !== 1'b0) begin
         fails++;
         $display("FAIL fill_inc_idle: Mem_Bus=%h busy=%b, want released and 0", mem_bus, busy);
      end
   endtask

   task automatic test_dump;
      bit ok;
      int sv, sc, sd;
      go(1'b1, 1'b1, 7'd5, 8'd3, 32'd1);
      wait_done(20, ok);
      repeat (2) @(negedge CLK);
      sv = od_q.size(); sc = cs_cyc.size(); sd = done_cyc.size();
      out_ready = 1'b1;
      go(1'b0, 1'b0, 7'd5, 8'd3, 32'd0);
      wait_done(30, ok);
      repeat (2) @(negedge CLK);
      tests++;
      if (!ok) begin fails++; $display("FAIL dump_done: no done within 30 cycles"); end
      tests++;
      if (od_q.size() - sv != 3 || cs_cyc.size() - sc != 3) begin
         fails++;
         $display("FAIL dump_counts: valid cycles %0d, CS cycles %0d, want 3 and 3", od_q.size() - sv, cs_cyc.size() - sc);
      end else begin
         for (int k = 0; k < 3; k++) begin
            tests++;
            if (od_q[sv+k] !== 32'(k + 1) || oa_q[sv+k] != 5 + k) begin
               fails++;
               $display("FAIL dump_word%0d: got data=%h addr=%0d, want data=%h addr=%0d", k, od_q[sv+k], oa_q[sv+k], k + 1, 5 + k);
            end
         end
         tests++;
         if (done_cyc.size() > sd && done_cyc[sd] - cs_cyc[sc] != 6) begin
            fails++;
            $display("FAIL dump_latency: %0d cycles from first RD to DONE, want 6", done_cyc[sd] - cs_cyc[sc]);
         end
      end
      out_ready = 1'b0;
   endtask

   task automatic test_backpressure;
      bit ok;
      int sc = cs_cyc.size();
      out_ready = 1'b0;
      go(1'b0, 1'b0, 7'd5, 8'd3, 32'd0);
      for (int w = 0; w < 3; w++) begin
         ok = 1'b0;
         for (int k = 0; k < 20 && !ok; k++) begin
            if (out_valid) ok = 1'b1;
            else @(negedge CLK);
         end
         tests++;
         if (!ok) begin fails++; $display("FAIL bp_valid%0d: out_valid never rose", w); end
         for (int k = 0; k < 5; k++) begin
            tests++;
            if (out_valid !== 1'b1 || out_data !== 32'(w + 1) || out_addr !== 7'(5 + w) || CS !== 1'b0) begin
               fails++;
               $display("FAIL bp_stall%0d_%0d: vld=%b data=%h addr=%0d cs=%b, want 1 %h %0d 0", w, k, out_valid, out_data, out_addr, CS, w + 1, 5 + w);
            end
            @(negedge CLK);
         end
         out_ready = 1'b1;
         @(negedge CLK);
         out_ready = 1'b0;
      end
      wait_done(10, ok);
      repeat (2) @(negedge CLK);
      tests++;
      if (!ok || cs_cyc.size() - sc != 3) begin
         fails++;
         $display("FAIL bp_end: done=%b CS cycles %0d, want done and 3", ok, cs_cyc.size() - sc);
      end
   endtask

   task automatic test_grant_loss;
      bit ok = 1'b0;
      int sw = wr_addr.size();
      go(1'b1, 1'b1, 7'h40, 8'd4, 32'h100);
      for (int k = 0; k < 20 && !ok; k++) begin
         if (CS && WE && ADDR == 7'h41) ok = 1'b1;
         else @(negedge CLK);
      end
      tests++;
      if (!ok) begin fails++; $display("FAIL gnt_reach: write to 0x41 never seen"); end
      bus_gnt = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge CLK);
         tests++;
         if (CS !== 1'b0) begin fails++; $display("FAIL gnt_gap%0d: CS=%b, want 0", k, CS); end
      end
      bus_gnt = 1'b1;
      wait_done(20, ok);
      repeat (2) @(negedge CLK);
      tests++;
      if (!ok || wr_addr.size() - sw != 4) begin
         fails++;
         $display("FAIL gnt_writes: done=%b writes=%0d, want done and 4", ok, wr_addr.size() - sw);
      end else begin
         for (int k = 0; k < 4; k++) begin
            tests++;
            if (wr_addr[sw+k] != 'h40 + k || ram[7'h40+k] !== 32'h100 + k) begin
               fails++;
               $display("FAIL gnt_word%0d: addr=%0h ram=%h, want %0h %h", k, wr_addr[sw+k], ram[7'h40+k], 'h40 + k, 32'h100 + k);
            end
         end
      end
   endtask

   task automatic test_reset_mid_wr;
      bit ok = 1'b0;
      int sw = wr_addr.size();
      go(1'b1, 1'b1, 7'h20, 8'd8, 32'h55AA0000);
      for (int k = 0; k < 20 && !ok; k++) begin
         if (CS && WE && ADDR == 7'h22) ok = 1'b1;
         else @(negedge CLK);
      end
      tests++;
      if (!ok) begin fails++; $display("FAIL rst_reach: write to 0x22 never seen"); end
      #1 RST_N = 1'b0;
      #1;
      tests++;
      if ({CS, WE, busy, bus_req} !== 4'b0) begin
         fails++;
         $display("FAIL rst_async: cs=%b we=%b busy=%b req=%b, want 0000", CS, WE, busy, bus_req);
      end
      tests++;
      if (mem_bus !== 32'bz && mem_bus !== 32'd0) begin
         fails++;
         $display("FAIL rst_bus: Mem_Bus=%h, want released", mem_bus);
      end
      repeat (3) @(negedge CLK);
      tests++;
      if (wr_addr.size() - sw != 3 || ram[7'h23] === 32'h55AA0003) begin
         fails++;
         $display("FAIL rst_abandon: writes=%0d ram[0x23]=%h, want 3 writes and no write to 0x23", wr_addr.size() - sw, ram[7'h23]);
      end
      RST_N = 1'b1;
   endtask

   task automatic test_noop;
      int sc = cs_cyc.size();
      go(1'b1, 1'b0, 7'd3, 8'd0, 32'hDEAD);
      tests++;
      if (done !== 1'b1 || busy !== 1'b1) begin
         fails++;
         $display("FAIL noop_done: done=%b busy=%b one cycle after start, want 1 1", done, busy);
      end
      @(negedge CLK);
      tests++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL noop_after: done=%b busy=%b, want 0 0", done, busy);
      end
      repeat (3) @(negedge CLK);
      tests++;
      if (cs_cyc.size() != sc) begin
         fails++;
         $display("FAIL noop_cs: %0d CS cycles, want 0", cs_cyc.size() - sc);
      end
   endtask

   task automatic test_wrap_clamp;
      bit ok;
      int sw = wr_addr.size(), bad = 0;
      go(1'b1, 1'b0, 7'd126, 8'd200, 32'hFFFFFFFF);
      wait_done(300, ok);
      repeat (2) @(negedge CLK);
      tests++;
      if (!ok || wr_addr.size() - sw != 128) begin
         fails++;
         $display("FAIL wrap_writes: done=%b writes=%0d, want done and 128", ok, wr_addr.size() - sw);
      end else begin
         tests++;
         if (wr_addr[sw] != 126 || wr_addr[sw+1] != 127 || wr_addr[sw+2] != 0 || wr_addr[sw+127] != 125) begin
            fails++;
            $display("FAIL wrap_order: got %0d %0d %0d .. %0d, want 126 127 0 .. 125", wr_addr[sw], wr_addr[sw+1], wr_addr[sw+2], wr_addr[sw+127]);
         end
      end
      for (int k = 0; k < 128; k++) if (ram[k] !== 32'hFFFFFFFF) bad++;
      tests++;
      if (bad != 0) begin
         fails++;
         $display("FAIL wrap_ram: %0d words differ, want 0 (all FFFFFFFF)", bad);
      end
   endtask

   initial begin
      test_reset();
      test_fill_inc();
      test_dump();
      test_backpressure();
      test_grant_loss();
      test_reset_mid_wr();
      test_noop();
      test_wrap_clamp();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/mem_dump_master.md
Name: mem_dump_master

Overview:
- Bus initiator on the CS/WE/ADDR/Mem_Bus memory interface, sharing the 128-word memory with the CPU through a bus_req/bus_gnt arbiter.
- Dump mode: reads a block of words from memory and streams them out over a valid/ready port, for display or UART debug.
- Fill mode: writes a constant or incrementing pattern into a block of memory, for test setup or clearing data.
- Acts as reader for words the CPU writes with sw, and as writer for words the CPU reads with lw.

Parameters:
- ADDR_W, 7, memory word-address width.
- DATA_W, 32, memory data width.
- MEM_WORDS, 128, memory depth; addresses wrap modulo this value.

Ports:
- CLK  in  1  system clock; all state updates on posedge.
- RST_N  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle command strobe; sampled only in IDLE.
- mode  in  1  0 = dump (read), 1 = fill (write).
- inc  in  1  fill only: 1 = write fill_data+i; 0 = write fill_data to every word.
- base_addr  in  ADDR_W  first word address.
- count  in  8  number of words.
- fill_data  in  DATA_W  fill seed value.
- bus_req  out  1  request for memory ownership.
- bus_gnt  in  1  ownership granted by the arbiter.
- CS  out  1  memory chip select.
- WE  out  1  memory write enable.
- ADDR  out  ADDR_W  memory word address.
- Mem_Bus  inout  DATA_W  shared tristate data bus.
- out_valid  out  1  dump word available.
- out_data  out  DATA_W  dumped word.
- out_addr  out  ADDR_W  address the dumped word came from.
- out_ready  in  1  consumer accepts the word.
- busy  out  1  high from command accept until DONE exits.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (async, RST_N=0):
  - State goes to IDLE; all outputs 0; ADDR 0; Mem_Bus released to Z immediately.
  - Any operation in progress is abandoned; no partial-word write completes after reset asserts.
- Memory timing:
  - Memory acts on the negedge of any cycle with CS=1.
  - Writes take effect at that negedge.
  - Read data is driven combinationally from the negedge until CS falls.
- States:
  - IDLE: on start, latch mode, inc, base_addr, fill_data and eff_cnt; clear index i; set busy. If eff_cnt=0 go to DONE, otherwise go to REQ.
  - REQ: bus_req=1. Go to RD (mode 0) or WR (mode 1) on the first cycle with bus_gnt=1.
  - RD: bus_req=1, CS=1, WE=0, ADDR=(base+i) mod 128. At the closing posedge, capture Mem_Bus into out_data and that address into out_addr, then go to HOLD.
  - HOLD: bus_req=1, CS=0, out_valid=1; out_data and out_addr held stable.
    - On out_ready: i++. If i+1=eff_cnt go to DONE; otherwise go to RD if bus_gnt=1, else REQ.
  - WR: bus_req=1, CS=1, WE=1, ADDR=(base+i) mod 128. Mem_Bus is driven with fill_data+i (inc=1, modulo 2^32) or fill_data (inc=0). i++. If last word go to DONE; otherwise stay in WR if bus_gnt=1, else go to REQ.
  - DONE: done=1 for one cycle, busy=0 on exit, bus_req=0, return to IDLE.
- Effective count: eff_cnt = count when 1..128; count=0 means no-op (done one cycle after start, no bus cycles); count>128 clamps to 128.
- Throughput:
  - Fill: one word per clock while granted.
  - Dump: minimum 2 clocks per word (RD + HOLD with out_ready already high).
- Bus drive rules:
  - Mem_Bus is driven only in WR; it is Z in every other state.
  - CS, WE and ADDR are driven only when bus_gnt=1; otherwise 0.
- Grant loss: if bus_gnt drops, the current cycle still completes. The next access waits in REQ and resumes at the same i; no word is skipped or repeated.
- Address wrap: base_addr=126, count=4 accesses 126, 127, 0, 1.
- Command handling: start while busy is ignored; start and reset together resolve to reset.

Decomposition:
- Shared package holds:
  - state enum {IDLE, REQ, RD, HOLD, WR, DONE};
  - ADDR_W, DATA_W, MEM_WORDS constants;
  - MODE_DUMP/MODE_FILL constants.
- Single module, no sub-module: the index/address counter and the tristate driver are small enough to stay inline.

Test Plan:
- Fill with inc=1: base=0x10, count=4, fill_data=0xA0 -> 4 consecutive WR cycles; RAM[0x10..0x13] = 0xA0, 0xA1, 0xA2, 0xA3; done pulses once; Mem_Bus is Z afterwards.
- Dump with out_ready tied high: preload RAM[5..7] = 1, 2, 3; base=5, count=3 -> out_data 1, 2, 3 with out_addr 5, 6, 7; each word has out_valid for exactly one cycle; 6 cycles from the first RD to DONE.
- Backpressure: dump with out_ready low for 5 cycles per word -> out_data/out_addr stay stable while out_valid=1; CS stays 0 while stalled; no words are lost.
- Wrap and clamp: fill with base=126, count=200, inc=0, fill_data=0xFFFFFFFF -> exactly 128 writes, addresses 126, 127, 0, …, 125; all RAM words = 0xFFFFFFFF.
- Grant loss: drop bus_gnt for 3 cycles in the middle of a 4-word fill -> CS=0 during the gap; the fill resumes at the next index; final RAM matches the uninterrupted case.
- Reset and no-op:
  - Assert RST_N=0 in the middle of WR -> CS, WE and busy go to 0 and Mem_Bus goes to Z asynchronously.
  - After release, start with count=0 -> done one cycle later and no CS activity.
